// File: rtl/cdc_pkg.sv
// Shared definitions for the req/ack clock-domain-crossing handshake blocks.
package cdc_pkg;

    // Four-phase handshake states, common to the launch and receive sides.
    typedef enum logic [1:0] {
        HS_IDLE = 2'b00,
        HS_REQ  = 2'b01,
        HS_REL  = 2'b10
    } hs_state_e;

endpackage

// File: rtl/cdc_sync.sv
// Multi-flop synchroniser for bringing an asynchronous signal into clk.
// Each bit is synchronised independently, so multi-bit use is only safe
// for signals that change one bit at a time or are otherwise qualified.
module cdc_sync #(
    parameter int DW = 1,
    parameter int N  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    logic [N-1:0][DW-1:0] sync_q;

    // Shift the asynchronous input through N flops to resolve metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[N-2:0], d};
        end
    end

    assign q = sync_q[N-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Launch side of a 4-phase req/ack handshake carrying one DW-bit word into
// another clock domain. The word is captured on accept and held on tx_data
// until the next accept; tx_req and tx_data come straight from flops.
module cdc_hs_tx
    import cdc_pkg::*;
#(
    parameter int DW     = 8,
    parameter int SYNC_N = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          tx_req,
    output logic [DW-1:0] tx_data,
    input  logic          tx_ack,
    output logic          busy,
    output logic          done
);

    hs_state_e      state_q, state_d;
    logic           tx_req_q, tx_req_d;
    logic [DW-1:0]  tx_data_q, tx_data_d;
    logic           done_q, done_d;
    logic           ack_s;

    cdc_sync #(
        .DW (1),
        .N  (SYNC_N)
    ) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (tx_ack),
        .q     (ack_s)
    );

    // A stale high ack (e.g. destination not reset with us) must be seen
    // low before a new request may be raised, otherwise the phases alias.
    assign s_ready = (state_q == HS_IDLE) && !ack_s;
    assign busy    = (state_q != HS_IDLE);
    assign tx_req  = tx_req_q;
    assign tx_data = tx_data_q;
    assign done    = done_q;

    // Next-state, request, data-capture and completion-pulse decisions.
    always_comb begin
        state_d   = state_q;
        tx_req_d  = tx_req_q;
        tx_data_d = tx_data_q;
        done_d    = 1'b0;
        case (state_q)
            HS_IDLE: begin
                if (s_valid && s_ready) begin
                    tx_data_d = s_data;
                    tx_req_d  = 1'b1;
                    state_d   = HS_REQ;
                end else begin
                    tx_req_d  = 1'b0;
                end
            end
            HS_REQ: begin
                // A falling ack here is a protocol violation and is ignored.
                if (ack_s) begin
                    tx_req_d = 1'b0;
                    state_d  = HS_REL;
                end else begin
                    tx_req_d = 1'b1;
                end
            end
            HS_REL: begin
                tx_req_d = 1'b0;
                if (!ack_s) begin
                    state_d = HS_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = HS_REL;
                end
            end
            default: begin
                state_d  = HS_IDLE;
                tx_req_d = 1'b0;
            end
        endcase
    end

    // Handshake state, launched word and done pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HS_IDLE;
            tx_req_q  <= 1'b0;
            tx_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_req_q  <= tx_req_d;
            tx_data_q <= tx_data_d;
            done_q    <= done_d;
        end
    end

endmodule
